// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash arbiter: flash opcodes, address
// width, FSM state encoding and the word byte-order helper.
package spi_flash_pkg;

   localparam int ADDR_W = 24;

   localparam logic [7:0] CMD_FAST_RD = 8'h0B;
   localparam logic [7:0] CMD_RLS_DPD = 8'hAB;

   typedef enum logic [3:0] {
      WAKE,
      WAKE_WAIT,
      IDLE,
      ARB,
      CMD,
      ADDR,
      DUMMY,
      DATA,
      DONE
   } state_t;

   // Flash bytes arrive MSB-first, first byte ends up in [31:24] of the
   // shift register; requesters want the first byte in [7:0].
   function automatic logic [31:0] byte_swap(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage

// File: rtl/spi_flash_shifter.sv
// SPI mode-3 bit engine. A load pulse starts a left-aligned field of
// nbits (1..32) bits: SCK falls and MOSI updates on the first clk of each
// bit, SCK rises and MISO is sampled on the second. field_end marks the
// cycle after the last rising edge; loading again in that cycle keeps
// SCK running without a gap.
module spi_flash_shifter (
   input  logic        clk,
   input  logic        resetn,
   input  logic        load,
   input  logic        stop,
   input  logic [31:0] field,
   input  logic [5:0]  nbits,
   input  logic        miso,
   output logic        sck,
   output logic        mosi,
   output logic        active,
   output logic        field_end,
   output logic [31:0] rx
);

   logic        phase;
   logic [5:0]  left;
   logic [31:0] tx;

   assign field_end = active && !phase && (left == 6'd0);

   // Bit sequencing: fall/shift-out on phase 0, rise/sample on phase 1.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sck    <= 1'b1;
         mosi   <= 1'b1;
         active <= 1'b0;
         phase  <= 1'b0;
         left   <= 6'd0;
         tx     <= 32'd0;
         rx     <= 32'd0;
      end else if (stop) begin
         sck    <= 1'b1;
         mosi   <= 1'b1;
         active <= 1'b0;
         phase  <= 1'b0;
         left   <= 6'd0;
      end else if (load) begin
         sck    <= 1'b0;
         mosi   <= field[31];
         tx     <= {field[30:0], 1'b0};
         left   <= nbits - 6'd1;
         phase  <= 1'b1;
         active <= 1'b1;
      end else if (active) begin
         if (phase) begin
            sck   <= 1'b1;
            rx    <= {rx[30:0], miso};
            phase <= 1'b0;
         end else if (left != 6'd0) begin
            sck   <= 1'b0;
            mosi  <= tx[31];
            tx    <= {tx[30:0], 1'b0};
            left  <= left - 6'd1;
            phase <= 1'b1;
         end else begin
            active <= 1'b0;
            mosi   <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/spi_flash_arbiter.sv
// Shares one SPI flash between NREQ read requesters. After reset the flash
// is woken from deep power-down (0xAB + WAKE_CYCLES with CSS high), then
// each granted request becomes one fast read (0x0B, 24-bit address,
// DUMMY_BITS dummy, len 32-bit words).
// Build option: SPI_FLASH_ARB_FIXED_PRIO_EN selects fixed priority (lowest
// index wins) instead of the default round-robin.
//
// state     | meaning
// WAKE      | shifting out 0xAB, CSS low
// WAKE_WAIT | CSS high, wake timer counting down
// IDLE      | waiting for any request
// ARB       | pick winner, latch its address and length
// CMD       | shifting out 0x0B
// ADDR      | shifting out the 24-bit start address
// DUMMY     | dummy bits, MOSI high
// DATA      | shifting in 32-bit words
// DONE      | o_done pulse, grant released
module spi_flash_arbiter
   import spi_flash_pkg::*;
#(
   parameter int NREQ        = 2,
   parameter int DUMMY_BITS  = 8,
   parameter int WAKE_CYCLES = 1000,
   parameter int LEN_W       = 16
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [NREQ-1:0]       i_req,
   input  logic [24*NREQ-1:0]    i_addr,
   input  logic [LEN_W*NREQ-1:0] i_len,
   output logic [NREQ-1:0]       o_gnt,
   output logic [NREQ-1:0]       o_valid,
   output logic [31:0]           o_data,
   output logic [NREQ-1:0]       o_done,
   output logic                  o_ready,
   output logic                  SPI_CSS,
   output logic                  SPI_CLK,
   output logic                  SPI_MOSI,
   input  logic                  SPI_MISO
);

   localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int TW = $clog2(WAKE_CYCLES + 1);

   state_t              state, state_next;
   logic                sh_load, sh_stop, sh_active, sh_end;
   logic [31:0]         sh_field, sh_rx;
   logic [5:0]          sh_nbits;
   logic                css_low, css_high, word_end, grant_now;
   logic                finish, abort, timer_load, ready_set;
   logic [TW-1:0]       timer;
   logic [LEN_W-1:0]    cnt;
   logic [ADDR_W-1:0]   addr_q;
   logic [SW-1:0]       win;
   logic [LEN_W-1:0]    win_len;
   logic                granted;

   assign win_len = i_len[win*LEN_W +: LEN_W];
   assign granted = |(i_req & o_gnt);

   spi_flash_shifter u_shifter (
      .clk       (clk),
      .resetn    (resetn),
      .load      (sh_load),
      .stop      (sh_stop),
      .field     (sh_field),
      .nbits     (sh_nbits),
      .miso      (SPI_MISO),
      .sck       (SPI_CLK),
      .mosi      (SPI_MOSI),
      .active    (sh_active),
      .field_end (sh_end),
      .rx        (sh_rx)
   );

`ifdef SPI_FLASH_ARB_FIXED_PRIO_EN
   // Winner: lowest-index active request.
   always_comb begin
      win = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (i_req[i]) win = SW'(i);
      end
   end
`else
   logic [SW-1:0]   ptr;
   logic [SW-1:0]   sel;
   logic [NREQ-1:0] req_rot;

   // Winner: first active request at or after the round-robin pointer.
   always_comb begin
      req_rot = NREQ'({i_req, i_req} >> ptr);
      win     = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req_rot[i]) win = SW'((int'(ptr) + i) % NREQ);
      end
   end

   // Pointer moves past the served requester on completion or abort.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ptr <= '0;
         sel <= '0;
      end else begin
         if (grant_now) sel <= win;
         if (finish || abort) ptr <= (sel == SW'(NREQ - 1)) ? '0 : sel + 1'b1;
      end
   end
`endif

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= WAKE;
      else         state <= state_next;
   end

   // Next state and per-cycle control strobes.
   always_comb begin
      state_next = state;
      sh_load    = 1'b0;
      sh_stop    = 1'b0;
      sh_field   = '1;
      sh_nbits   = 6'd32;
      css_low    = 1'b0;
      css_high   = 1'b0;
      word_end   = 1'b0;
      grant_now  = 1'b0;
      finish     = 1'b0;
      abort      = 1'b0;
      timer_load = 1'b0;
      ready_set  = 1'b0;
      case (state)
         WAKE: begin
            if (!sh_active) begin
               sh_load  = 1'b1;
               sh_field = {CMD_RLS_DPD, 24'h0};
               sh_nbits = 6'd8;
               css_low  = 1'b1;
            end else if (sh_end) begin
               css_high   = 1'b1;
               timer_load = 1'b1;
               state_next = WAKE_WAIT;
            end
         end
         WAKE_WAIT: begin
            if (timer == '0) begin
               ready_set  = 1'b1;
               state_next = IDLE;
            end
         end
         IDLE: begin
            if (|i_req) state_next = ARB;
         end
         ARB: begin
            if (|i_req) begin
               grant_now  = 1'b1;
               state_next = (win_len == '0) ? DONE : CMD;
            end else begin
               state_next = IDLE;
            end
         end
         CMD, ADDR, DUMMY, DATA: begin
            if (!granted) begin
               abort      = 1'b1;
               sh_stop    = 1'b1;
               css_high   = 1'b1;
               state_next = IDLE;
            end else begin
               case (state)
                  CMD: begin
                     if (!sh_active) begin
                        sh_load  = 1'b1;
                        sh_field = {CMD_FAST_RD, 24'h0};
                        sh_nbits = 6'd8;
                        css_low  = 1'b1;
                     end else if (sh_end) begin
                        sh_load    = 1'b1;
                        sh_field   = {addr_q, 8'h0};
                        sh_nbits   = 6'(ADDR_W);
                        state_next = ADDR;
                     end
                  end
                  ADDR: begin
                     if (sh_end) begin
                        sh_load    = 1'b1;
                        sh_nbits   = 6'(DUMMY_BITS);
                        state_next = DUMMY;
                     end
                  end
                  DUMMY: begin
                     if (sh_end) begin
                        sh_load    = 1'b1;
                        state_next = DATA;
                     end
                  end
                  default: begin
                     if (sh_end) begin
                        word_end = 1'b1;
                        if (cnt == LEN_W'(1)) begin
                           css_high   = 1'b1;
                           state_next = DONE;
                        end else begin
                           sh_load = 1'b1;
                        end
                     end
                  end
               endcase
            end
         end
         DONE: begin
            finish     = 1'b1;
            state_next = IDLE;
         end
         default: state_next = WAKE;
      endcase
   end

   // Chip select, grant, word delivery, timers and request latches.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         SPI_CSS <= 1'b1;
         o_gnt   <= '0;
         o_valid <= '0;
         o_done  <= '0;
         o_data  <= 32'd0;
         o_ready <= 1'b0;
         timer   <= '0;
         cnt     <= '0;
         addr_q  <= '0;
      end else begin
         o_valid <= '0;
         o_done  <= '0;
         if (css_low)       SPI_CSS <= 1'b0;
         else if (css_high) SPI_CSS <= 1'b1;
         if (ready_set) o_ready <= 1'b1;
         if (timer_load)                           timer <= TW'(WAKE_CYCLES - 1);
         else if (state == WAKE_WAIT && timer != '0) timer <= timer - 1'b1;
         if (grant_now) begin
            o_gnt  <= NREQ'(1) << win;
            addr_q <= i_addr[win*ADDR_W +: ADDR_W];
            cnt    <= win_len;
         end
         if (word_end) begin
            o_valid <= o_gnt;
            o_data  <= byte_swap(sh_rx);
            cnt     <= cnt - 1'b1;
         end
         if (finish) begin
            o_done <= o_gnt;
            o_gnt  <= '0;
         end
         if (abort) o_gnt <= '0;
      end
   end

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Directed bench for spi_flash_arbiter with a behavioural SPI flash whose
// byte at address a is a[7:0].
module tb_spi_flash_arbiter;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [1:0]  i_req = 2'b00;
   logic [47:0] i_addr = 48'd0;
   logic [31:0] i_len = 32'd0;
   logic [1:0]  o_gnt, o_valid, o_done;
   logic [31:0] o_data;
   logic        o_ready, SPI_CSS, SPI_CLK, SPI_MOSI;
   logic        SPI_MISO = 1'b1;

   int total = 0;
   int bad = 0;

   spi_flash_arbiter #(
      .NREQ(2), .DUMMY_BITS(8), .WAKE_CYCLES(1000), .LEN_W(16)
   ) dut (
      .clk(clk), .resetn(resetn), .i_req(i_req), .i_addr(i_addr),
      .i_len(i_len), .o_gnt(o_gnt), .o_valid(o_valid), .o_data(o_data),
      .o_done(o_done), .o_ready(o_ready), .SPI_CSS(SPI_CSS),
      .SPI_CLK(SPI_CLK), .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO)
   );

   always #5 clk = ~clk;

   // Flash model: samples MOSI on SCK rise, drives MISO on SCK fall.
   int          fbits = 0;
   logic [63:0] fhdr = 64'd0;
   logic [7:0]  f_cmd = 8'd0;
   logic [7:0]  f_dummy = 8'd0;
   logic [23:0] f_addr = 24'd0;
   logic [23:0] fb;
   int          fd;

   always @(negedge SPI_CSS) begin
      fbits = 0;
      fhdr  = 64'd0;
   end

   always @(posedge SPI_CLK) begin
      if (!SPI_CSS) begin
         fhdr  = {fhdr[62:0], SPI_MOSI};
         fbits = fbits + 1;
         if (fbits == 8)  f_cmd   = fhdr[7:0];
         if (fbits == 32) f_addr  = fhdr[23:0];
         if (fbits == 40) f_dummy = fhdr[7:0];
      end
   end

   always @(negedge SPI_CLK) begin
      if (!SPI_CSS && fbits >= 40) begin
         fd       = fbits - 40;
         fb       = f_addr + 24'(fd / 8);
         SPI_MISO = fb[7 - (fd % 8)];
      end
   end

   task automatic wake_watch(output int n_low, output int n_high,
                             output bit gnt_seen, output bit ready);
      n_low = 0; n_high = 0; gnt_seen = 1'b0; ready = 1'b0;
      for (int c = 0; c < 1200; c++) begin
         @(negedge clk);
         if (o_ready) begin
            ready = 1'b1;
            break;
         end
         if (|o_gnt) gnt_seen = 1'b1;
         if (!SPI_CSS) n_low++;
         else if (n_low > 0) n_high++;
      end
   endtask

   task automatic test_reset();
      int n_low, n_high, done_k;
      bit gnt_seen, ready;
      resetn = 1'b0;
      i_addr[23:0] = 24'h000000;
      i_len[15:0]  = 16'd0;
      i_req        = 2'b01;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if ({SPI_CSS, SPI_CLK, SPI_MOSI} !== 3'b111) begin bad++; $display("FAIL reset_spi: got %b exp 111", {SPI_CSS, SPI_CLK, SPI_MOSI}); end
      total++; if ({o_gnt, o_valid, o_done, o_ready} !== 7'd0) begin bad++; $display("FAIL reset_ctl: got %b exp 0", {o_gnt, o_valid, o_done, o_ready}); end
      total++; if (o_data !== 32'd0) begin bad++; $display("FAIL reset_data: got %h exp 0", o_data); end
      resetn = 1'b1;
      wake_watch(n_low, n_high, gnt_seen, ready);
      total++; if (n_low !== 16) begin bad++; $display("FAIL wake_css_low: got %0d exp 16", n_low); end
      total++; if (n_high !== 1000) begin bad++; $display("FAIL wake_css_high: got %0d exp 1000", n_high); end
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL wake_ready: got %b exp 1", ready); end
      total++; if (gnt_seen !== 1'b0) begin bad++; $display("FAIL early_gnt: got %b exp 0", gnt_seen); end
      total++; if (f_cmd !== 8'hAB || fbits !== 8) begin bad++; $display("FAIL wake_cmd: got %h/%0d exp ab/8", f_cmd, fbits); end
      done_k = -1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (o_done[0]) begin
            done_k = k;
            i_req[0] = 1'b0;
            break;
         end
      end
      total++; if (done_k !== 3) begin bad++; $display("FAIL pending_done: got %0d exp 3", done_k); end
      @(negedge clk);
   endtask

   task automatic test_single();
      logic [31:0] exp_w [3];
      int vt [3];
      int first_sck, nvalid, ndone, done_k;
      bit css_at_done;
      exp_w = '{32'h03020100, 32'h07060504, 32'h0B0A0908};
      vt = '{-1, -1, -1};
      first_sck = -1; nvalid = 0; ndone = 0; done_k = -1; css_at_done = 1'b0;
      i_addr[23:0] = 24'h020000;
      i_len[15:0]  = 16'd3;
      i_req[0]     = 1'b1;
      for (int k = 1; k <= 400; k++) begin
         @(negedge clk);
         if (first_sck < 0 && !SPI_CLK) first_sck = k;
         if (o_valid[0]) begin
            if (nvalid < 3) begin
               vt[nvalid] = k;
               total++; if (o_data !== exp_w[nvalid]) begin bad++; $display("FAIL single_word%0d: got %h exp %h", nvalid, o_data, exp_w[nvalid]); end
            end
            nvalid++;
         end
         if (o_done[0]) begin
            ndone++;
            done_k = k;
            css_at_done = SPI_CSS;
            i_req[0] = 1'b0;
            break;
         end
      end
      total++; if (first_sck !== 3) begin bad++; $display("FAIL req_to_sck: got %0d exp 3", first_sck); end
      total++; if (f_cmd !== 8'h0B || f_addr !== 24'h020000 || f_dummy !== 8'hFF) begin bad++; $display("FAIL header: got %h %h %h exp 0b 020000 ff", f_cmd, f_addr, f_dummy); end
      total++; if (vt[0] !== 147 || vt[1] !== 211 || vt[2] !== 275) begin bad++; $display("FAIL valid_times: got %0d %0d %0d exp 147 211 275", vt[0], vt[1], vt[2]); end
      total++; if (nvalid !== 3 || ndone !== 1 || done_k !== 276) begin bad++; $display("FAIL single_done: got %0d/%0d@%0d exp 3/1@276", nvalid, ndone, done_k); end
      total++; if (css_at_done !== 1'b1) begin bad++; $display("FAIL css_after: got %b exp 1", css_at_done); end
      @(negedge clk);
   endtask

   task automatic test_zero_len();
      int gnt_k, done_k, ndone;
      bit css_seen_low;
      gnt_k = -1; done_k = -1; ndone = 0; css_seen_low = 1'b0;
      i_addr[47:24] = 24'h000300;
      i_len[31:16]  = 16'd0;
      i_req[1]      = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (!SPI_CSS || !SPI_CLK) css_seen_low = 1'b1;
         if (o_gnt[1] && gnt_k < 0) gnt_k = k;
         if (o_done[1]) begin
            ndone++;
            done_k = k;
            i_req[1] = 1'b0;
         end
      end
      total++; if (gnt_k !== 2 || done_k !== 3 || ndone !== 1) begin bad++; $display("FAIL zero_len: got gnt@%0d done@%0d n=%0d exp 2 3 1", gnt_k, done_k, ndone); end
      total++; if (css_seen_low !== 1'b0) begin bad++; $display("FAIL zero_len_spi: got %b exp 0", css_seen_low); end
      total++; if (o_gnt !== 2'b00) begin bad++; $display("FAIL zero_len_gnt: got %b exp 00", o_gnt); end
   endtask

   task automatic test_round_robin();
      int exp_order [4];
      int order [4];
      int ng, n0, n1, run, min_gap;
      bit seen_low, finished;
      logic [1:0] prev_gnt;
`ifdef SPI_FLASH_ARB_FIXED_PRIO_EN
      exp_order = '{0, 0, 1, 1};
`else
      exp_order = '{0, 1, 0, 1};
`endif
      order = '{-1, -1, -1, -1};
      ng = 0; n0 = 0; n1 = 0; run = 0; min_gap = 9999;
      seen_low = 1'b0; finished = 1'b0; prev_gnt = 2'b00;
      i_addr = {24'h000080, 24'h000010};
      i_len  = {16'd1, 16'd1};
      i_req  = 2'b11;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (o_gnt != 2'b00 && prev_gnt == 2'b00) begin
            if (ng < 4) order[ng] = o_gnt[1] ? 1 : 0;
            ng++;
         end
         prev_gnt = o_gnt;
         if (SPI_CSS) run++;
         else begin
            if (seen_low && run > 0 && run < min_gap) min_gap = run;
            run = 0;
            seen_low = 1'b1;
         end
         if (o_valid[0]) begin
            total++; if (o_data !== 32'h13121110) begin bad++; $display("FAIL rr_data0: got %h exp 13121110", o_data); end
         end
         if (o_valid[1]) begin
            total++; if (o_data !== 32'h83828180) begin bad++; $display("FAIL rr_data1: got %h exp 83828180", o_data); end
         end
         if (o_done[0]) begin
            n0++;
            if (n0 == 2) i_req[0] = 1'b0;
         end
         if (o_done[1]) begin
            n1++;
            if (n1 == 2) i_req[1] = 1'b0;
         end
         if (i_req == 2'b00) begin
            finished = 1'b1;
            break;
         end
      end
      total++; if (finished !== 1'b1 || ng !== 4) begin bad++; $display("FAIL rr_count: got fin=%b grants=%0d exp 1 4", finished, ng); end
      for (int i = 0; i < 4; i++) begin
         total++; if (order[i] !== exp_order[i]) begin bad++; $display("FAIL rr_order%0d: got %0d exp %0d", i, order[i], exp_order[i]); end
      end
      total++; if (min_gap < 2) begin bad++; $display("FAIL css_gap: got %0d exp >=2", min_gap); end
      @(negedge clk);
   endtask

   task automatic test_abort();
      logic [31:0] exp1 [2];
      int n0, n1, done0, done1, abort_k;
      bit raised1;
      exp1 = '{32'h53525150, 32'h57565554};
      n0 = 0; n1 = 0; done0 = 0; done1 = 0; abort_k = -1; raised1 = 1'b0;
      i_addr = {24'h000150, 24'h000000};
      i_len  = {16'd2, 16'd100};
      i_req  = 2'b01;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (abort_k >= 0 && k == abort_k + 1) begin
            total++; if ({SPI_CSS, SPI_CLK, o_gnt} !== 4'b1100) begin bad++; $display("FAIL abort_state: got %b exp 1100", {SPI_CSS, SPI_CLK, o_gnt}); end
         end
         if (o_gnt[0] && !raised1) begin
            i_req[1] = 1'b1;
            raised1 = 1'b1;
         end
         if (o_valid[0]) begin
            n0++;
            if (n0 == 10) begin
               total++; if (o_data !== 32'h27262524) begin bad++; $display("FAIL abort_word10: got %h exp 27262524", o_data); end
               i_req[0] = 1'b0;
               abort_k = k;
            end
         end
         if (o_done[0]) done0++;
         if (o_valid[1]) begin
            if (n1 < 2) begin
               total++; if (o_data !== exp1[n1]) begin bad++; $display("FAIL after_abort_word%0d: got %h exp %h", n1, o_data, exp1[n1]); end
            end
            n1++;
         end
         if (o_done[1]) begin
            done1++;
            i_req[1] = 1'b0;
            break;
         end
      end
      total++; if (n0 !== 10 || done0 !== 0) begin bad++; $display("FAIL abort_req0: got words=%0d done=%0d exp 10 0", n0, done0); end
      total++; if (n1 !== 2 || done1 !== 1) begin bad++; $display("FAIL abort_req1: got words=%0d done=%0d exp 2 1", n1, done1); end
      total++; if (f_addr !== 24'h000150) begin bad++; $display("FAIL abort_req1_addr: got %h exp 000150", f_addr); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int n_low, n_high;
      bit gnt_seen, ready, got_valid;
      got_valid = 1'b0;
      i_addr[23:0] = 24'h000000;
      i_len[15:0]  = 16'd5;
      i_req        = 2'b01;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (o_valid[0]) begin
            got_valid = 1'b1;
            break;
         end
      end
      total++; if (got_valid !== 1'b1) begin bad++; $display("FAIL mid_first_word: got %b exp 1", got_valid); end
      repeat (5) @(negedge clk);
      resetn = 1'b0;
      #1;
      total++; if ({SPI_CSS, SPI_CLK, SPI_MOSI} !== 3'b111) begin bad++; $display("FAIL mid_reset_spi: got %b exp 111", {SPI_CSS, SPI_CLK, SPI_MOSI}); end
      total++; if ({o_gnt, o_valid, o_done, o_ready} !== 7'd0 || o_data !== 32'd0) begin bad++; $display("FAIL mid_reset_out: got %b %h exp 0 0", {o_gnt, o_valid, o_done, o_ready}, o_data); end
      i_req = 2'b00;
      @(negedge clk);
      resetn = 1'b1;
      wake_watch(n_low, n_high, gnt_seen, ready);
      total++; if (n_low !== 16 || n_high !== 1000 || ready !== 1'b1) begin bad++; $display("FAIL rewake: got %0d %0d %b exp 16 1000 1", n_low, n_high, ready); end
      total++; if (f_cmd !== 8'hAB) begin bad++; $display("FAIL rewake_cmd: got %h exp ab", f_cmd); end
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_zero_len();
      test_round_robin();
      test_abort();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_flash_arbiter.md
Name: spi_flash_arbiter

Overview:
- Owns the single SPI flash port and shares it between NREQ read requesters, e.g. the RISC-V code loader and the CNN weight/FIFO loaders.
- On leaving reset, issues a one-time release-from-deep-power-down (0xAB) and waits WAKE_CYCLES.
- Then serves requests: each request is a start address plus a word count.
- For each granted request it issues fast read (0x0B), 24-bit address and dummy bits, then streams 32-bit words back to the granted requester.

Parameters:
- NREQ, 2, number of requesters (2..4).
- DUMMY_BITS, 8, SCK cycles between the last address bit and the first data bit.
- WAKE_CYCLES, 1000, clk cycles CSS is held high after 0xAB (≥10 us at the system clock).
- LEN_W, 16, width of the word-count field.

Ports:
- clk  in  1  system clock (RISC-V clock)
- resetn  in  1  asynchronous reset, active-low
- i_req  in  NREQ  per-requester request level; held high until o_done, dropping it aborts
- i_addr  in  24*NREQ  flash byte start address, slice k = [24k+23:24k]
- i_len  in  LEN_W*NREQ  32-bit words to read, slice k
- o_gnt  out  NREQ  one-hot grant, high from grant until o_done/abort
- o_valid  out  NREQ  one-cycle word strobe to the granted requester
- o_data  out  32  assembled word; first flash byte in [7:0]
- o_done  out  NREQ  one-cycle pulse after the last word of a request
- o_ready  out  1  wake sequence complete
- SPI_CSS  out  1  flash chip select, active-low
- SPI_CLK  out  1  flash SCK
- SPI_MOSI  out  1  flash data in
- SPI_MISO  in  1  flash data out

Behaviour:
- Reset values:
  - SPI_CSS=1, SPI_CLK=1, SPI_MOSI=1.
  - o_gnt=0, o_valid=0, o_done=0, o_data=0, o_ready=0.
  - Round-robin pointer = 0; FSM = WAKE.
- SPI timing:
  - Mode 3: SCK idles high, one SPI bit = 2 clk.
  - SCK falls on the first clk of a bit and MOSI updates then.
  - SCK rises on the second clk and MISO is sampled then. MSB-first on the wire.
- FSM states:
  - WAKE: 8 bits of 0xAB, CSS low.
  - WAKE_WAIT: CSS high, WAKE_CYCLES count. Exit sets o_ready=1, go to IDLE.
  - IDLE: if any i_req, go to ARB.
  - ARB (1 clk): pick the winner, assert its o_gnt next clk, latch its addr/len.
    - len==0: go to DONE with no SPI activity.
    - Otherwise go to CMD.
  - CMD: 8 bits of 0x0B.
  - ADDR: 24 bits, addr[23] first.
  - DUMMY: DUMMY_BITS with MOSI=1.
  - DATA: shift 32 bits per word.
    - After each 32nd sample, o_data = byte-swapped shift register and o_valid[k]=1 for 1 clk; remaining count decrements.
    - At count 0, CSS goes high on the next clk; go to DONE.
  - DONE (1 clk): o_done[k]=1, o_gnt cleared, pointer = k+1 mod NREQ, go to IDLE.
- Arbitration:
  - Round-robin starting at the pointer; only the ARB state samples i_req.
  - Requests arriving during a transfer wait; there is no preemption.
- CSS gap: at least 2 clk high between consecutive transactions (DONE + ARB).
- Abort: i_req[k] drops while granted → next clk CSS=1, SCK=1, o_gnt=0, partial word discarded, no o_done; go to IDLE and advance the pointer.
- Requests before o_ready are held pending and are not granted.
- Address arithmetic: no wrap handling; the flash auto-increments internally, and a transfer crossing 0xFFFFFF wraps in the device.
- The length counter is LEN_W bits; len = 2^LEN_W−1 is legal.
- Latency:
  - From req rise in IDLE to the first SCK falling edge: 3 clk.
  - From there to the first o_valid: (8+24+DUMMY_BITS+32)*2 clk.

Optional Feature:
- SPI_FLASH_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins; pointer logic removed.
- Undefined (default): round-robin as above.

Decomposition:
- Shared package spi_flash_pkg holds:
  - Command constants CMD_FAST_RD=8'h0B and CMD_RLS_DPD=8'hAB.
  - The FSM state encoding (4-bit enum WAKE..DONE).
  - Address width 24.
- One sub-module, spi_flash_shifter: SCK generation, MOSI shift-out of an N-bit field, MISO 32-bit shift-in, bit counter. The arbiter FSM sequences field loads into it.

Test Plan:
- Reset release: first 16 clk show 0xAB on MOSI with CSS low, then CSS high for 1000 clk → o_ready=1; no o_gnt before that.
- req0, addr 0x020000, len 3, flash model returns bytes 00..0B:
  - MOSI shows 0x0B, then 0x020000, then 8 dummy bits.
  - o_valid[0] fires three times with o_data 0x03020100, 0x07060504, 0x0B0A0908; o_done[0] once; CSS high after.
- req0 and req1 asserted together, len 1 each, twice: grants alternate 0,1,0,1. With SPI_FLASH_ARB_FIXED_PRIO_EN: 0,0 while req0 stays asserted.
- req1 with len 0 → o_gnt[1] then o_done[1] within 3 clk; CSS stays high throughout.
- req0 len 100, drop req0 after word 10 → CSS high next clk, no o_done[0]; a pending req1 is then granted and completes correctly.
- Assert resetn low mid-DATA → all outputs return to reset values immediately and the wake sequence repeats.
